// File: rtl/paddle_move_sched.sv
// paddle_move_sched: owns both paddle positions, arbitrates move requests round-robin and streams erase/draw pixels to one plotter.
// Define PADDLE_WRAP_EN to wrap moves past a screen edge instead of clamping at it.
module paddle_move_sched #(
  parameter int SCREEN_H = 240,
  parameter int PADDLE_W = 10,
  parameter int PADDLE_H = 40,
  parameter int STEP = 10,
  parameter int X_LEFT = 0,
  parameter int X_RIGHT = 310,
  parameter logic [2:0] PADDLE_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] up_req,
  input  logic [1:0] down_req,
  input  logic       plot_ready,
  output logic       plot,
  output logic [8:0] plot_x,
  output logic [7:0] plot_y,
  output logic [2:0] plot_colour,
  output logic [7:0] p0_y,
  output logic [7:0] p1_y,
  output logic       busy,
  output logic       move_done
);
  localparam int Y_LIM = SCREEN_H - PADDLE_H;
  localparam logic [7:0] Y_INIT = 8'(Y_LIM / 2);
  localparam int XW = $clog2(PADDLE_W + 1);
  localparam int YW = $clog2(PADDLE_H + 1);
  localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, ERASE = 2'd2, DRAW = 2'd3;
  logic [1:0] state, pend_up, pend_dn, elig, clr_up, clr_dn;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [7:0] y_cur, gy, ny, ny_r;
  logic [8:0] up_y, dn_y;
  logic run, cur, last, g, g_up, grant, fire, cx_end, last_px;
  assign elig = pend_up ^ pend_dn;
  assign g = &elig ? ~last : elig[1];
  assign g_up = pend_up[g];
  assign gy = g ? p1_y : p0_y;
  assign grant = state == IDLE && |elig;
`ifdef PADDLE_WRAP_EN
  assign up_y = gy >= 8'(STEP) ? 9'(gy) - 9'(STEP) : 9'(Y_LIM);
  assign dn_y = 9'(gy) + 9'(STEP) <= 9'(Y_LIM) ? 9'(gy) + 9'(STEP) : 9'd0;
`else
  assign up_y = gy >= 8'(STEP) ? 9'(gy) - 9'(STEP) : 9'd0;
  assign dn_y = 9'(gy) + 9'(STEP) <= 9'(Y_LIM) ? 9'(gy) + 9'(STEP) : 9'(Y_LIM);
`endif
  assign ny = 8'(g_up ? up_y : dn_y);
  // Conflicting flags cancel each other; the granted flag is consumed even when the move is a no-op.
  assign clr_up = (pend_up & pend_dn) | ((grant && g_up) ? 2'b01 << g : 2'b00);
  assign clr_dn = (pend_up & pend_dn) | ((grant && !g_up) ? 2'b01 << g : 2'b00);
  assign busy = state != IDLE;
  assign plot = run && busy;
  assign fire = plot && plot_ready;
  assign cx_end = cx == XW'(PADDLE_W - 1);
  assign last_px = cx_end && cy == YW'(PADDLE_H - 1);
  assign y_cur = cur ? p1_y : p0_y;
  assign plot_x = plot ? 9'(cur ? X_RIGHT : X_LEFT) + 9'(cx) : 9'd0;
  assign plot_y = plot ? y_cur + 8'(cy) : 8'd0;
  assign plot_colour = !plot ? 3'b000 : state == ERASE ? BG_COLOUR : PADDLE_COLOUR;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= INIT;
      run <= 1'b0;
      cur <= 1'b0;
      last <= 1'b1;
      pend_up <= 2'b00;
      pend_dn <= 2'b00;
      cx <= '0;
      cy <= '0;
      p0_y <= Y_INIT;
      p1_y <= Y_INIT;
      ny_r <= 8'd0;
      move_done <= 1'b0;
    end else begin
      run <= 1'b1;
      move_done <= 1'b0;
      pend_up <= (pend_up & ~clr_up) | up_req;
      pend_dn <= (pend_dn & ~clr_dn) | down_req;
      if (grant && ny != gy) begin
        state <= ERASE;
        cur <= g;
        ny_r <= ny;
      end
      if (fire) begin
        cx <= cx_end ? '0 : cx + 1'b1;
        if (cx_end) cy <= last_px ? '0 : cy + 1'b1;
      end
      if (fire && last_px) begin
        if (state == INIT) begin
          cur <= 1'b1;
          if (cur) state <= IDLE;
        end else if (state == ERASE) begin
          state <= DRAW;
          if (cur) p1_y <= ny_r;
          else p0_y <= ny_r;
        end else begin
          state <= IDLE;
          move_done <= 1'b1;
          last <= cur;
        end
      end
    end
endmodule

// File: tb/tb_paddle_move_sched.sv
// tb_paddle_move_sched: accepted-pixel stream and paddle positions checked against a rectangle-level model of the sequencer.
module tb_paddle_move_sched;
  logic clock, resetn, plot_ready, plot, busy, move_done;
  logic [1:0] up_req, down_req;
  logic [8:0] plot_x;
  logic [7:0] plot_y, p0_y, p1_y;
  logic [2:0] plot_colour;
  logic [19:0] got[$], exp_q[$];
  int ncmp, nerr, md_cnt, md_exp, mlast;
  int my[2];
  bit rnd_ready;

  paddle_move_sched dut (
    .clock(clock), .resetn(resetn), .up_req(up_req), .down_req(down_req),
    .plot_ready(plot_ready), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .p0_y(p0_y), .p1_y(p1_y), .busy(busy), .move_done(move_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    plot_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      plot_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clock) begin
    if (plot && plot_ready) got.push_back({plot_x, plot_y, plot_colour});
    if (move_done) md_cnt++;
  end

  function automatic int up_y(int y);
`ifdef PADDLE_WRAP_EN
    return y < 10 ? 200 : y - 10;
`else
    return y < 10 ? 0 : y - 10;
`endif
  endfunction

  function automatic int dn_y(int y);
`ifdef PADDLE_WRAP_EN
    return y + 10 > 200 ? 0 : y + 10;
`else
    return y + 10 > 200 ? 200 : y + 10;
`endif
  endfunction

  task automatic rect(input int p, input int y, input logic [2:0] c);
    for (int r = 0; r < 40; r++)
      for (int k = 0; k < 10; k++)
        exp_q.push_back({9'(p ? 310 + k : k), 8'(y + r), c});
  endtask

  task automatic model_init();
    my[0] = 100;
    my[1] = 100;
    mlast = 1;
    rect(0, 100, 3'b111);
    rect(1, 100, 3'b111);
  endtask

  task automatic model_serve(input logic [1:0] u, input logic [1:0] d);
    logic [1:0] pu, pd;
    int g, ny;
    pu = u & ~(u & d);
    pd = d & ~(u & d);
    while ((pu | pd) != 2'b00) begin
      g = ((pu[0] | pd[0]) && (pu[1] | pd[1])) ? 1 - mlast : ((pu[1] | pd[1]) ? 1 : 0);
      ny = pu[g] ? up_y(my[g]) : dn_y(my[g]);
      pu[g] = 1'b0;
      pd[g] = 1'b0;
      if (ny != my[g]) begin
        rect(g, my[g], 3'b000);
        rect(g, ny, 3'b111);
        my[g] = ny;
        mlast = g;
        md_exp++;
      end
    end
  endtask

  task automatic scn_begin();
    got.delete();
    exp_q.delete();
    md_cnt = 0;
    md_exp = 0;
  endtask

  function automatic int first_diff();
    int n;
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    return got.size() == exp_q.size() ? -1 : n;
  endfunction

  function automatic logic [19:0] gpx(input bit from_exp, input int i);
    if (from_exp) return i < exp_q.size() ? exp_q[i] : 'x;
    return i < got.size() ? got[i] : 'x;
  endfunction

  task automatic pulse(input logic [1:0] u, input logic [1:0] d);
    @(posedge clock);
    #1;
    up_req = u;
    down_req = d;
    @(posedge clock);
    #1;
    up_req = 2'b00;
    down_req = 2'b00;
  endtask

  task automatic wait_idle();
    int n, streak;
    n = 0;
    streak = 0;
    while (streak < 4 && n < 20000) begin
      @(negedge clock);
      n++;
      streak = busy ? 0 : streak + 1;
    end
    if (streak < 4) begin
      ncmp++;
      nerr++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, want busy=0", busy, n);
    end
  endtask

  task automatic test_reset();
    int d;
    #2 resetn = 1'b0;
    #1;
    ncmp++;
    if ({plot, plot_x, plot_y, plot_colour, move_done, busy, p0_y, p1_y} !==
        {1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd100, 8'd100}) begin
      nerr++;
      $display("FAIL reset_state: got plot=%b x=%0d y=%0d c=%0d md=%b busy=%b p0=%0d p1=%0d want 0 0 0 0 0 1 100 100",
               plot, plot_x, plot_y, plot_colour, move_done, busy, p0_y, p1_y);
    end
    repeat (2) @(posedge clock);
    #1;
    scn_begin();
    model_init();
    resetn = 1'b1;
    wait_idle();
    ncmp++;
    if (got.size() !== 800) begin nerr++; $display("FAIL init_count: got %0d want 800", got.size()); end
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL init_stream: pixel %0d got %h want %h", d, gpx(0, d), gpx(1, d)); end
    ncmp++;
    if (gpx(0, 0) !== {9'd0, 8'd100, 3'd7}) begin nerr++; $display("FAIL init_first: got %h want %h", gpx(0, 0), {9'd0, 8'd100, 3'd7}); end
    ncmp++;
    if (gpx(0, 799) !== {9'd319, 8'd139, 3'd7}) begin nerr++; $display("FAIL init_last: got %h want %h", gpx(0, 799), {9'd319, 8'd139, 3'd7}); end
    ncmp++;
    if ({busy, p0_y, p1_y, 32'(md_cnt)} !== {1'b0, 8'd100, 8'd100, 32'd0}) begin
      nerr++;
      $display("FAIL init_end: got busy=%b p0=%0d p1=%0d md=%0d want 0 100 100 0", busy, p0_y, p1_y, md_cnt);
    end
  endtask

  task automatic test_single_move();
    int n, d;
    scn_begin();
    pulse(2'b01, 2'b00);
    model_serve(2'b01, 2'b00);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!move_done && n < 2000);
    ncmp++;
    if (n !== 802) begin nerr++; $display("FAIL single_latency: move_done at cycle %0d want 802 (801 after grant)", n); end
    ncmp++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL single_idle_at_done: busy=%b want 0", busy); end
    wait_idle();
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL single_stream: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (md_cnt !== md_exp) begin nerr++; $display("FAIL single_done: got %0d pulses want %0d", md_cnt, md_exp); end
    ncmp++;
    if (p0_y !== 8'(my[0]) || p1_y !== 8'(my[1])) begin nerr++; $display("FAIL single_y: got %0d/%0d want %0d/%0d", p0_y, p1_y, my[0], my[1]); end
  endtask

  task automatic test_tie();
    int d;
    scn_begin();
    pulse(2'b11, 2'b00);
    model_serve(2'b11, 2'b00);
    wait_idle();
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL tie_stream: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (md_cnt !== md_exp) begin nerr++; $display("FAIL tie_done: got %0d pulses want %0d", md_cnt, md_exp); end
    ncmp++;
    if (p0_y !== 8'(my[0]) || p1_y !== 8'(my[1])) begin nerr++; $display("FAIL tie_y: got %0d/%0d want %0d/%0d", p0_y, p1_y, my[0], my[1]); end
  endtask

  task automatic test_back_to_back();
    int d;
    scn_begin();
    pulse(2'b01, 2'b00);
    model_serve(2'b01, 2'b00);
    repeat (5) @(posedge clock);
    #1;
    ncmp++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy: got %b want 1", busy); end
    pulse(2'b10, 2'b01);
    pulse(2'b10, 2'b00);
    model_serve(2'b10, 2'b01);
    wait_idle();
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL b2b_stream: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (md_cnt !== md_exp) begin nerr++; $display("FAIL b2b_done: got %0d pulses want %0d", md_cnt, md_exp); end
    ncmp++;
    if (p0_y !== 8'(my[0]) || p1_y !== 8'(my[1])) begin nerr++; $display("FAIL b2b_y: got %0d/%0d want %0d/%0d", p0_y, p1_y, my[0], my[1]); end
  endtask

  task automatic test_limit();
    int d;
    scn_begin();
    while (my[0] != 0) begin
      pulse(2'b01, 2'b00);
      model_serve(2'b01, 2'b00);
      wait_idle();
    end
    pulse(2'b01, 2'b00);
    model_serve(2'b01, 2'b00);
    wait_idle();
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL limit_stream: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (md_cnt !== md_exp) begin nerr++; $display("FAIL limit_done: got %0d pulses want %0d", md_cnt, md_exp); end
    ncmp++;
    if (p0_y !== 8'(my[0]) || p1_y !== 8'(my[1])) begin nerr++; $display("FAIL limit_y: got %0d/%0d want %0d/%0d", p0_y, p1_y, my[0], my[1]); end
  endtask

  task automatic test_conflict();
    int d;
    scn_begin();
    pulse(2'b10, 2'b10);
    model_serve(2'b10, 2'b10);
    wait_idle();
    ncmp++;
    if (got.size() !== 0 || md_cnt !== 0 || p1_y !== 8'(my[1])) begin
      nerr++;
      $display("FAIL conflict_noop: got %0d pixels %0d pulses p1=%0d want 0 0 %0d", got.size(), md_cnt, p1_y, my[1]);
    end
    pulse(2'b00, 2'b10);
    model_serve(2'b00, 2'b10);
    wait_idle();
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL conflict_after: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (p0_y !== 8'(my[0]) || p1_y !== 8'(my[1])) begin nerr++; $display("FAIL conflict_y: got %0d/%0d want %0d/%0d", p0_y, p1_y, my[0], my[1]); end
  endtask

  task automatic test_random();
    int d;
    logic [1:0] u, dn;
    scn_begin();
    rnd_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      u = 2'($urandom_range(0, 3));
      dn = 2'($urandom_range(0, 3));
      pulse(u, dn);
      model_serve(u, dn);
      wait_idle();
    end
    rnd_ready = 1'b0;
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL random_stream: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (md_cnt !== md_exp) begin nerr++; $display("FAIL random_done: got %0d pulses want %0d", md_cnt, md_exp); end
    ncmp++;
    if (p0_y !== 8'(my[0]) || p1_y !== 8'(my[1])) begin nerr++; $display("FAIL random_y: got %0d/%0d want %0d/%0d", p0_y, p1_y, my[0], my[1]); end
  endtask

  task automatic test_reset_mid();
    int d;
    scn_begin();
    rnd_ready = 1'b1;
    if (my[0] < 200) pulse(2'b00, 2'b01);
    else pulse(2'b01, 2'b00);
    repeat (50) @(posedge clock);
    #1;
    ncmp++;
    if (busy !== 1'b1 || plot !== 1'b1) begin nerr++; $display("FAIL midreset_pre: busy=%b plot=%b want 1 1", busy, plot); end
    resetn = 1'b0;
    #1;
    ncmp++;
    if (plot !== 1'b0 || p0_y !== 8'd100 || p1_y !== 8'd100 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL midreset_state: plot=%b p0=%0d p1=%0d busy=%b want 0 100 100 1", plot, p0_y, p1_y, busy);
    end
    rnd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    scn_begin();
    model_init();
    resetn = 1'b1;
    wait_idle();
    d = first_diff();
    ncmp++;
    if (d >= 0) begin nerr++; $display("FAIL midreset_init: pixel %0d got %h want %h (sizes %0d/%0d)", d, gpx(0, d), gpx(1, d), got.size(), exp_q.size()); end
    ncmp++;
    if (p0_y !== 8'd100 || p1_y !== 8'd100 || md_cnt !== 0) begin nerr++; $display("FAIL midreset_end: p0=%0d p1=%0d md=%0d want 100 100 0", p0_y, p1_y, md_cnt); end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rnd_ready = 1'b0;
    up_req = 2'b00;
    down_req = 2'b00;
    resetn = 1'b1;
    test_reset();
    test_single_move();
    test_tie();
    test_back_to_back();
    test_limit();
    test_conflict();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
